// File: rtl/pay_disp_pkg.sv
// Shared glyph table, FSM state type and helpers for the payment result display.
// Glyphs are 7-bit active-high {g,f,e,d,c,b,a}; the top level inverts for the pins.
package pay_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        CHG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DP_BIT = 7;

    localparam logic [6:0] G_S   = 7'h6D;
    localparam logic [6:0] G_U   = 7'h3E;
    localparam logic [6:0] G_C   = 7'h39;
    localparam logic [6:0] G_E   = 7'h79;
    localparam logic [6:0] G_D   = 7'h5E;  // lower-case d
    localparam logic [6:0] G_F   = 7'h71;
    localparam logic [6:0] G_A   = 7'h77;
    localparam logic [6:0] G_I   = 7'h06;
    localparam logic [6:0] G_L   = 7'h38;
    localparam logic [6:0] G_H   = 7'h76;
    localparam logic [6:0] G_N   = 7'h54;  // lower-case n
    localparam logic [6:0] G_G   = 7'h6F;  // lower-case g
    localparam logic [6:0] BLANK = 7'h00;
    localparam logic [6:0] DASH  = 7'h40;

    // pos counts down from the top digit: pos 0 is digit NUM_DIGITS-1.
    function automatic logic [6:0] msg_glyph(input logic fail, input int unsigned pos);
        logic [6:0] g;
        g = BLANK;
        if (fail) begin
            case (pos)
                0: g = G_F;
                1: g = G_A;
                2: g = G_I;
                3: g = G_L;
                default: g = BLANK;
            endcase
        end else begin
            case (pos)
                0: g = G_S;
                1: g = G_U;
                2, 3: g = G_C;
                4, 5: g = G_E;
                6: g = G_D;
                default: g = BLANK;
            endcase
        end
        return g;
    endfunction

    function automatic logic [6:0] chg_text_glyph(input int unsigned pos);
        logic [6:0] g;
        case (pos)
            0: g = G_C;
            1: g = G_H;
            2: g = G_A;
            3: g = G_N;
            4: g = G_G;
            5: g = G_E;
            default: g = BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// One BCD nibble to a 7-bit active-high glyph; non-decimal codes show a dash.
module seg7_bcd_decode
    import pay_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = DASH;
        case (bcd)
            4'd0: glyph = 7'h3F;
            4'd1: glyph = 7'h06;
            4'd2: glyph = 7'h5B;
            4'd3: glyph = 7'h4F;
            4'd4: glyph = 7'h66;
            4'd5: glyph = 7'h6D;
            4'd6: glyph = 7'h7D;
            4'd7: glyph = 7'h07;
            4'd8: glyph = 7'h7F;
            4'd9: glyph = 7'h6F;
            default: glyph = DASH;
        endcase
    end

endmodule

// File: rtl/pay_result_display.sv
// End-of-transaction 7-seg display: alternates result message and change amount, then blanks.
// Optional build macro PAY_DISP_ZERO_BLANK_EN blanks leading zeros of the change amount.
module pay_result_display
    import pay_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned CHG_DIGITS  = 2,
    parameter int unsigned SCAN_DIV    = 12500,
    parameter int unsigned PHASE_TICKS = 12000,
    parameter int unsigned REPEAT      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    result_fail,
    input  logic [4*CHG_DIGITS-1:0] change_bcd,
    output logic [NUM_DIGITS-1:0]   seg_en,
    output logic [7:0]              seg_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned PH_W   = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam int unsigned PAIR_W = $clog2(REPEAT + 1);

    state_t                  state, state_nxt;
    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [PH_W-1:0]         phase_cnt;
    logic [PAIR_W-1:0]       pair_cnt;
    logic                    fail_q;
    logic [4*CHG_DIGITS-1:0] chg_q;
    logic [6:0]              chg_glyph [CHG_DIGITS];
    logic [CHG_DIGITS-1:0]   chg_blank;
    logic                    active, accept, tick, phase_end;
    logic [6:0]              glyph;
    logic                    dp;
    logic [7:0]              lit;
    logic [NUM_DIGITS-1:0]   en_nxt;
    int unsigned             pos;

    assign active    = (state == MSG) || (state == CHG);
    assign accept    = start && !active;
    assign tick      = active && (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign phase_end = tick && (phase_cnt == PH_W'(PHASE_TICKS - 1));
    assign busy      = active;
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = MSG;
            MSG:        if (phase_end) state_nxt = CHG;
            // pair_cnt counts completed pairs, so the current one is pair_cnt+1
            CHG:        if (phase_end)
                            state_nxt = (pair_cnt < PAIR_W'(REPEAT - 1)) ? MSG : DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            scan_idx  <= '0;
            phase_cnt <= '0;
            pair_cnt  <= '0;
            fail_q    <= 1'b0;
            chg_q     <= '0;
        end else if (accept) begin
            div_cnt   <= '0;
            scan_idx  <= '0;
            phase_cnt <= '0;
            pair_cnt  <= '0;
            fail_q    <= result_fail;
            chg_q     <= change_bcd;
        end else if (active) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                scan_idx  <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
                phase_cnt <= phase_end ? '0 : phase_cnt + PH_W'(1);
            end
            if (phase_end && state == CHG) pair_cnt <= pair_cnt + PAIR_W'(1);
        end
    end

    for (genvar k = 0; k < CHG_DIGITS; k++) begin : g_dec
        seg7_bcd_decode u_dec (
            .bcd   (chg_q[4*k +: 4]),
            .glyph (chg_glyph[k])
        );
    end

`ifdef PAY_DISP_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        chg_blank = '0;
        lead      = 1'b1;
        for (int unsigned k = CHG_DIGITS - 1; k >= 1; k--) begin
            if (lead && chg_q[4*k +: 4] == 4'd0) chg_blank[k] = 1'b1;
            else                                  lead         = 1'b0;
        end
    end
`else
    assign chg_blank = '0;
`endif

    always_comb begin
        glyph  = BLANK;
        dp     = 1'b0;
        en_nxt = '1;
        pos    = NUM_DIGITS - 1 - int'(scan_idx);
        if (state == MSG) begin
            glyph = msg_glyph(fail_q, pos);
        end else if (state == CHG) begin
            glyph = chg_text_glyph(pos);
            dp    = (pos == 5);
            for (int unsigned k = 0; k < CHG_DIGITS; k++) begin
                if (scan_idx == IDX_W'(k)) glyph = chg_blank[k] ? BLANK : chg_glyph[k];
            end
        end
        if (active) en_nxt[scan_idx] = 1'b0;
        lit         = {1'b0, glyph};
        lit[DP_BIT] = dp;
    end

    // Enables and segments share one register stage so they switch on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_en  <= '1;
            seg_out <= 8'hFF;
        end else begin
            seg_en  <= en_nxt;
            seg_out <= ~lit;
        end
    end

endmodule

// File: tb/tb_pay_result_display.sv
// Randomised self-checking bench for pay_result_display against a text-level display model.
// Expectations follow PAY_DISP_ZERO_BLANK_EN when the build defines it.
module tb_pay_result_display;

    localparam int ND = 8;
    localparam int CD = 2;
    localparam int SD = 4;
    localparam int PT = 8;
    localparam int RP = 2;
    localparam int BUSY_CYC = 2 * RP * PT * SD;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            result_fail;
    logic [4*CD-1:0] change_bcd;
    logic [ND-1:0]   seg_en;
    logic [7:0]      seg_out;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pay_result_display #(
        .NUM_DIGITS  (ND),
        .CHG_DIGITS  (CD),
        .SCAN_DIV    (SD),
        .PHASE_TICKS (PT),
        .REPEAT      (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .result_fail (result_fail),
        .change_bcd  (change_bcd),
        .seg_en      (seg_en),
        .seg_out     (seg_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] char_glyph(input byte c);
        case (c)
            "S": return 7'b1101101;
            "U": return 7'b0111110;
            "C": return 7'b0111001;
            "E": return 7'b1111001;
            "d": return 7'b1011110;
            "F": return 7'b1110001;
            "A": return 7'b1110111;
            "I": return 7'b0000110;
            "L": return 7'b0111000;
            "H": return 7'b1110110;
            "n": return 7'b1010100;
            "g": return 7'b1101111;
            "0": return 7'b0111111;
            "1": return 7'b0000110;
            "2": return 7'b1011011;
            "3": return 7'b1001111;
            "4": return 7'b1100110;
            "5": return 7'b1101101;
            "6": return 7'b1111101;
            "7": return 7'b0000111;
            "8": return 7'b1111111;
            "9": return 7'b1101111;
            "-": return 7'b1000000;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] change_glyph(input logic [7:0] bcd, input int k);
        int v;
        v = (bcd >> (4 * k)) & 15;
`ifdef PAY_DISP_ZERO_BLANK_EN
        if (k > 0 && (bcd >> (4 * k)) == 0) return 7'b0000000;
`endif
        if (v > 9) return char_glyph("-");
        return char_glyph(byte'(48 + v));
    endfunction

    // n = rising edges since the accepting edge; outputs lag the state by one edge.
    function automatic void model(input logic f, input logic [7:0] bcd, input int n,
                                  output logic [7:0] en, output logic [7:0] seg);
        int m, idx, phase, pos;
        string txt;
        logic [7:0] on;
        en  = 8'hFF;
        seg = 8'hFF;
        if (n < 1 || n > BUSY_CYC) return;
        m     = n - 1;
        idx   = (m / SD) % ND;
        phase = m / (SD * PT);
        pos   = ND - 1 - idx;
        on    = 8'h00;
        if (phase % 2 == 0) begin
            txt = f ? "FAIL" : "SUCCEEd";
        end else begin
            txt = "CHAngE";
            if (idx == ND - 6) on[7] = 1'b1;
            if (idx < CD) on[6:0] = change_glyph(bcd, idx);
        end
        if (pos < txt.len()) on[6:0] = char_glyph(txt[pos]);
        en  = ~(8'h01 << idx);
        seg = ~on;
    endfunction

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_seg_en"}, seg_en, 8'hFF);
        check({tag, "_seg_out"}, seg_out, 8'hFF);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, exp_done);
    endtask

    task automatic run_txn(input logic f, input logic [7:0] b, input int ign_at, input int rst_at);
        logic [7:0] een, eseg;
        @(negedge clk);
        start       = 1'b1;
        result_fail = f;
        change_bcd  = b;
        for (int n = 0; n <= BUSY_CYC + 3; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 0) begin
                result_fail = 1'($urandom);
                change_bcd  = 8'($urandom);
            end
            model(f, b, n, een, eseg);
            check("seg_en", seg_en, een);
            check("seg_out", seg_out, eseg);
            check("busy", busy, n < BUSY_CYC);
            check("done", done, n >= BUSY_CYC);
            if (n == ign_at) begin
                start       = 1'b1;
                result_fail = ~f;
                change_bcd  = 8'($urandom);
            end
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check_idle("rst_mid", 1'b0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check_idle("post_rst", 1'b0);
                end
                return;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        result_fail = 1'b0;
        change_bcd  = '0;
        #2;
        check_idle("reset", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("idle", 1'b0);
        end

        run_txn(1'b0, 8'h37, -1, -1);
        run_txn(1'b1, 8'h05, 10, -1);
        run_txn(1'b0, 8'hA0, -1, -1);
        run_txn(1'b0, 8'h05, -1, -1);
        run_txn(1'b0, 8'h00, -1, -1);
        run_txn(1'b1, 8'h91, -1, 40);
        for (int t = 0; t < 8; t++) begin
            run_txn(1'($urandom), 8'($urandom), int'($urandom_range(1, 120)),
                    (t % 4 == 3) ? int'($urandom_range(2, 126)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
